pwm_multi: RTL and testbench

Memory-mapped, parametrised multi-channel PWM peripheral on the CPU native memory bus (valid/ready/wstrb/addr/wdata/rdata). It is the next generation of the single-channel PWM: N independent channels, configurable counter width, edge- or center-aligned modes, output polarity, and double-buffered period/duty that update glitch-free at the period boundary. It sits beside the other memory-mapped peripherals, with the top level providing address decode into `valid`.

---
 rtl/pwm_multi_pkg.sv | 12 +
 rtl/pwm_multi_channel.sv | 56 +++++
 rtl/pwm_multi.sv | 103 ++++++++++
 tb/tb_pwm_multi.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_multi_pkg.sv
// pwm_multi_pkg: register map offsets, CTRL bit indices and channel stride shared by the PWM peripheral
package pwm_multi_pkg;
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PERIOD = 2'd1;
  localparam logic [1:0] REG_DUTY   = 2'd2;
  localparam logic [1:0] REG_COUNT  = 2'd3;
  localparam int CTRL_EN     = 0;
  localparam int CTRL_CENTER = 1;
  localparam int CTRL_POL    = 2;
  localparam int CTRL_IRQ_EN = 3;
  localparam int STRIDE      = 4;
endpackage

// File: rtl/pwm_multi_channel.sv
// pwm_multi_channel: one PWM channel with double-buffered period/duty, edge/center counter and registered output
// en/center/pol: channel mode; per_we/duty_we + per_w/duty_w: shadow writes (already byte-merged)
// per_sh/duty_sh: shadow readback; count: live counter; pwm: registered output; bnd: period-boundary pulse
module pwm_multi_channel
  import pwm_multi_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             center,
  input  logic             pol,
  input  logic             per_we,
  input  logic             duty_we,
  input  logic [CNT_W-1:0] per_w,
  input  logic [CNT_W-1:0] duty_w,
  output logic [CNT_W-1:0] per_sh,
  output logic [CNT_W-1:0] duty_sh,
  output logic [CNT_W-1:0] count,
  output logic             pwm,
  output logic             bnd
);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  logic [CNT_W-1:0] per_act, duty_act, cnt_n;
  logic dir, dir_n, at_top, down, hold;
  // center boundary is the step that lands on 0 while falling, so the next period starts at 0 with new values
  always_comb begin
    at_top = count >= per_act;
    down = dir | at_top;
    hold = center ? (per_act == '0) : at_top;
    bnd = en & (center ? (hold | (down & (count == ONE))) : at_top);
    cnt_n = (!en || hold) ? '0 : (center && down) ? count - ONE : count + ONE;
    dir_n = en & center & down & (count > ONE);
  end
  always_ff @(posedge clk)
    if (reset) begin
      per_sh <= '0;
      duty_sh <= '0;
      per_act <= '0;
      duty_act <= '0;
      count <= '0;
      dir <= 1'b0;
      pwm <= 1'b0;
    end else begin
      count <= cnt_n;
      dir <= dir_n;
      pwm <= en ? (count < duty_act) ^ pol : pol;
      if (per_we) per_sh <= per_w;
      if (duty_we) duty_sh <= duty_w;
      if (bnd || !en) begin
        per_act <= per_sh;
        duty_act <= duty_sh;
      end
    end
endmodule

// File: rtl/pwm_multi.sv
// pwm_multi: memory-mapped multi-channel PWM peripheral on the native valid/ready bus
// valid/ready/wstrb/addr/wdata/rdata: bus slave (addr[7:2] decoded, wstrb==0 is a read)
// pwm_out: one registered output per channel; irq: registered period-end interrupt
// Define PWM_MULTI_IRQ_EN to build STATUS, CTRL.IRQ_EN and irq; otherwise they read 0 / stay 0.
module pwm_multi
  import pwm_multi_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid,
  output logic                ready,
  input  logic [3:0]          wstrb,
  input  logic [31:0]         addr,
  input  logic [31:0]         wdata,
  output logic [31:0]         rdata,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                irq
);
`ifdef PWM_MULTI_IRQ_EN
  localparam logic [3:0] CTRL_MASK = 4'hF;
`else
  localparam logic [3:0] CTRL_MASK = 4'hF & ~(4'b1 << CTRL_IRQ_EN);
`endif
  logic [5:0] off;
  logic [31:0] mask, rd_mux;
  logic wr, unused_bits;
  logic [3:0] ctrl [CHANNELS];
  logic [CNT_W-1:0] per_sh [CHANNELS];
  logic [CNT_W-1:0] duty_sh [CHANNELS];
  logic [CNT_W-1:0] count [CHANNELS];
  logic [CHANNELS-1:0] bnd, status;
  assign off = addr[7:2];
  assign mask = {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
  assign wr = valid & ready & (|wstrb);
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic hit;
    logic [3:0] ctrl_r;
    logic [CNT_W-1:0] per_w, duty_w;
    assign hit = wr && off[5:2] == 4'(c);
    assign per_w = CNT_W'((32'(per_sh[c]) & ~mask) | (wdata & mask));
    assign duty_w = CNT_W'((32'(duty_sh[c]) & ~mask) | (wdata & mask));
    assign ctrl[c] = ctrl_r;
    always_ff @(posedge clk)
      if (reset) ctrl_r <= '0;
      else if (hit && off[1:0] == REG_CTRL) ctrl_r <= (ctrl_r & ~mask[3:0]) | (wdata[3:0] & mask[3:0] & CTRL_MASK);
    pwm_multi_channel #(.CNT_W(CNT_W)) u_ch (
      .clk     (clk),
      .reset   (reset),
      .en      (ctrl_r[CTRL_EN]),
      .center  (ctrl_r[CTRL_CENTER]),
      .pol     (ctrl_r[CTRL_POL]),
      .per_we  (hit && off[1:0] == REG_PERIOD),
      .duty_we (hit && off[1:0] == REG_DUTY),
      .per_w   (per_w),
      .duty_w  (duty_w),
      .per_sh  (per_sh[c]),
      .duty_sh (duty_sh[c]),
      .count   (count[c]),
      .pwm     (pwm_out[c]),
      .bnd     (bnd[c])
    );
  end
`ifdef PWM_MULTI_IRQ_EN
  logic [CHANNELS-1:0] irq_en, clr;
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ie
    assign irq_en[c] = ctrl[c][CTRL_IRQ_EN];
  end
  assign clr = (wr && off == 6'(STRIDE * CHANNELS)) ? wdata[CHANNELS-1:0] & mask[CHANNELS-1:0] : '0;
  // set wins over a same-cycle W1C so no boundary event is lost
  always_ff @(posedge clk)
    if (reset) begin
      status <= '0;
      irq <= 1'b0;
    end else begin
      status <= (status & ~clr) | (bnd & irq_en);
      irq <= |(status & irq_en);
    end
  assign unused_bits = ^{addr[31:8], addr[1:0]};
`else
  assign status = '0;
  assign irq = 1'b0;
  assign unused_bits = ^{addr[31:8], addr[1:0], bnd};
`endif
  always_comb begin
    rd_mux = '0;
    for (int c = 0; c < CHANNELS; c++)
      if (off[5:2] == 4'(c))
        rd_mux = off[1:0] == REG_CTRL ? 32'(ctrl[c]) : off[1:0] == REG_PERIOD ? 32'(per_sh[c]) :
                 off[1:0] == REG_DUTY ? 32'(duty_sh[c]) : off[1:0] == REG_COUNT ? 32'(count[c]) : '0;
    if (off == 6'(STRIDE * CHANNELS)) rd_mux = 32'(status);
  end
  always_ff @(posedge clk)
    if (reset) begin
      ready <= 1'b0;
      rdata <= '0;
    end else begin
      ready <= valid & ~ready;
      rdata <= (valid & ~ready) ? rd_mux : '0;
    end
endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi: scoreboard bench for pwm_multi (bus reads and pwm run lengths checked against queued expectations)
module tb_pwm_multi;
  localparam int CH = 4;
`ifdef PWM_MULTI_IRQ_EN
  localparam logic [31:0] CTRL_ALL = 32'hF;
`else
  localparam logic [31:0] CTRL_ALL = 32'h7;
`endif
  typedef struct packed {
    logic        rd;
    logic [31:0] d;
  } item_t;
  logic clk = 1'b0;
  logic reset, valid, ready, irq;
  logic [3:0] wstrb;
  logic [31:0] addr, wdata, rdata;
  logic [CH-1:0] pwm_out;
  int n_chk = 0;
  int n_err = 0;
  item_t sb_q[$];
  item_t mon_it;
  int run_q[$];
  int run_len = 0;

  always #5 clk = ~clk;

  pwm_multi #(.CHANNELS(CH), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .valid(valid), .ready(ready), .wstrb(wstrb),
    .addr(addr), .wdata(wdata), .rdata(rdata), .pwm_out(pwm_out), .irq(irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ra(input int c, input int r);
    return 32'((4 * c + r) * 4);
  endfunction

  function automatic int center_high(input int p, input int d);
    int h = 0;
    for (int i = 0; i < 2 * p; i++) if (((i <= p) ? i : 2 * p - i) < d) h++;
    return h;
  endfunction

  always @(negedge clk)
    if (ready) begin
      check("sb_pending", sb_q.size() > 0, 1);
      if (sb_q.size() > 0) begin
        mon_it = sb_q.pop_front();
        if (mon_it.rd) check("rdata", rdata, mon_it.d);
      end
    end

  always @(negedge clk)
    if (pwm_out[0]) run_len++;
    else begin
      if (run_len > 0 && run_q.size() > 0) check("run_len", run_len, run_q.pop_front());
      run_len = 0;
    end

  task automatic xfer(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d, input logic [31:0] e);
    item_t it;
    int n;
    @(negedge clk);
    addr = a;
    wstrb = s;
    wdata = d;
    valid = 1'b1;
    it.rd = (s == 4'h0);
    it.d = e;
    sb_q.push_back(it);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ready && n < 8);
    check("ready_lat", n, 1);
    @(posedge clk);
    #1 valid = 1'b0;
    wstrb = 4'h0;
    @(negedge clk);
    check("ready_pulse", ready, 0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    xfer(a, s, d, 32'h0);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e);
    xfer(a, 4'h0, 32'h0, e);
  endtask

  task automatic measure(input int ch, input int cyc, output int h);
    h = 0;
    repeat (cyc) begin
      @(negedge clk);
      h += int'(pwm_out[ch]);
    end
  endtask

  task automatic wait_rise(input int ch, output int n);
    logic prev;
    n = 0;
    prev = pwm_out[ch];
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (!prev && pwm_out[ch]) break;
      prev = pwm_out[ch];
    end
    check("rise_timeout", n >= 200, 0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, h;
    reset = 1'b1;
    valid = 1'b1;
    addr = 32'h0;
    wstrb = 4'h0;
    wdata = 32'h0;
    repeat (3) begin
      @(negedge clk);
      check("rst_ready", ready, 0);
    end
    check("rst_rdata", rdata, 0);
    check("rst_pwm", pwm_out, 0);
    check("rst_irq", irq, 0);
    valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int o = 0; o <= 4 * CH + 1; o++) rd(32'(o * 4), 32'h0);
    check("rdata_idle", rdata, 0);
    wr(ra(CH, 1), 4'hF, 32'hFFFF_FFFF);
    rd(ra(CH, 1), 32'h0);
    wr(ra(3, 1), 4'hF, 32'h1234_0009);
    rd(ra(3, 1), 32'h9);
    wr(ra(3, 2), 4'hF, 32'h3);
    wr(ra(3, 2), 4'b0010, 32'h0000_AB55);
    rd(ra(3, 2), 32'hAB03);
    wr(ra(3, 0), 4'b0010, 32'hFFFF);
    rd(ra(3, 0), 32'h0);
    wr(ra(3, 0), 4'h1, 32'hFF);
    rd(ra(3, 0), CTRL_ALL);
    wr(ra(3, 0), 4'h1, 32'h0);
    wr(ra(0, 1), 4'hF, 32'd9);
    wr(ra(0, 2), 4'hF, 32'd3);
    wr(ra(0, 0), 4'h1, 32'h1);
    repeat (5) @(negedge clk);
    measure(0, 30, h);
    check("edge_high", h, 9);
    wr(ra(0, 0), 4'h1, 32'h5);
    repeat (5) @(negedge clk);
    measure(0, 30, h);
    check("edge_pol_high", h, 21);
    wr(ra(0, 0), 4'h1, 32'h1);
    wr(ra(1, 1), 4'hF, 32'd8);
    wr(ra(1, 2), 4'hF, 32'd4);
    wr(ra(1, 0), 4'h1, 32'h3);
    repeat (5) @(negedge clk);
    measure(1, 32, h);
    check("center_high", h, 2 * center_high(8, 4));
    wait_rise(1, n);
    wait_rise(1, n);
    check("center_period", n, 16);
    wait_rise(0, n);
    run_q.push_back(3);
    run_q.push_back(7);
    repeat (2) @(negedge clk);
    wr(ra(0, 2), 4'hF, 32'd7);
    repeat (30) @(negedge clk);
    check("runs_mid_left", run_q.size(), 0);
    wait_rise(0, n);
    run_q.push_back(7);
    run_q.push_back(7);
    run_q.push_back(2);
    repeat (6) @(negedge clk);
    wr(ra(0, 2), 4'hF, 32'd2);
    repeat (40) @(negedge clk);
    check("runs_bnd_left", run_q.size(), 0);
    wr(ra(0, 2), 4'hF, 32'd0);
    repeat (25) @(negedge clk);
    measure(0, 20, h);
    check("duty0_high", h, 0);
    wr(ra(0, 2), 4'hF, 32'd12);
    repeat (25) @(negedge clk);
    measure(0, 20, h);
    check("duty_over_high", h, 20);
    wr(ra(0, 2), 4'hF, 32'd3);
    repeat (25) @(negedge clk);
    wr(ra(0, 0), 4'h1, 32'h4);
    repeat (2) @(negedge clk);
    measure(0, 10, h);
    check("dis_pol_high", h, 10);
    rd(ra(0, 3), 32'h0);
`ifdef PWM_MULTI_IRQ_EN
    wr(ra(CH, 0), 4'hF, 32'hF);
    wr(ra(2, 1), 4'hF, 32'd4);
    wr(ra(2, 0), 4'h1, 32'h9);
    n = 0;
    while (!irq && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("irq_latency", n, 6);
    rd(ra(CH, 0), 32'h4);
    wr(ra(2, 0), 4'h1, 32'h8);
    wr(ra(CH, 0), 4'hF, 32'h4);
    rd(ra(CH, 0), 32'h0);
    repeat (2) @(negedge clk);
    check("irq_cleared", irq, 0);
`else
    wr(ra(2, 1), 4'hF, 32'd4);
    wr(ra(2, 0), 4'h1, 32'h9);
    h = 0;
    repeat (20) begin
      @(negedge clk);
      h += int'(irq);
    end
    check("irq_off", h, 0);
    rd(ra(CH, 0), 32'h0);
    rd(ra(2, 0), 32'h1);
`endif
    repeat (3) @(negedge clk);
    check("sb_left", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
